// File: rtl/nor_pipe_unit_if.sv
// Operand/result handshake bundle for nor_pipe_unit.
// The master drives operands and y_ready; the slave (the unit) returns results.
interface nor_pipe_unit_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y;
   logic             y_valid;
   logic             y_ready;
   logic             y_zero;
   logic             y_ones;

   modport master (
      output a, b, mode, in_valid, y_ready,
      input  in_ready, y, y_valid, y_zero, y_ones
   );

   modport slave (
      input  a, b, mode, in_valid, y_ready,
      output in_ready, y, y_valid, y_zero, y_ones
   );
endinterface

// File: rtl/nor_pipe_unit.sv
// Two-stage valid/ready pipeline applying a NOR-family bitwise op, with
// registered zero/ones flags, a sticky OR accumulator and a transfer counter.
module nor_pipe_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   nor_pipe_unit_if.slave       bus,
   input  logic                 acc_clr,
   output logic [WIDTH-1:0]     acc,
   output logic [CNT_W-1:0]     txn_count
);
   typedef enum logic [1:0] {
      OP_NOR  = 2'b00,
      OP_OR   = 2'b01,
      OP_NAND = 2'b10,
      OP_AND  = 2'b11
   } op_e;

   logic             s1_valid;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   op_e              mode1;

   logic [WIDTH-1:0] y_q;
   logic             y_valid_q;
   logic             y_zero_q;
   logic             y_ones_q;

   logic             s2_free;
   logic             in_fire;
   logic             out_fire;
   logic             advance;
   logic [WIDTH-1:0] op_res;

   // Only in_ready depends combinationally on y_ready; all other outputs are registered.
   assign s2_free      = !y_valid_q || bus.y_ready;
   assign bus.in_ready = !s1_valid || s2_free;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign out_fire     = y_valid_q && bus.y_ready;
   assign advance      = s1_valid && s2_free;

   always_comb begin
      op_res = '0;
      case (mode1)
         OP_NOR:  op_res = ~(a1 | b1);
         OP_OR:   op_res = a1 | b1;
         OP_NAND: op_res = ~(a1 & b1);
         OP_AND:  op_res = a1 & b1;
         default: op_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         a1        <= '0;
         b1        <= '0;
         mode1     <= OP_NOR;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         y_zero_q  <= 1'b0;
         y_ones_q  <= 1'b0;
         acc       <= '0;
         txn_count <= '0;
      end else begin
         if (in_fire) begin
            a1       <= bus.a;
            b1       <= bus.b;
            mode1    <= op_e'(bus.mode);
            s1_valid <= 1'b1;
         end else if (advance) begin
            s1_valid <= 1'b0;
         end

         // y and flags hold their last value after draining.
         if (advance) begin
            y_q       <= op_res;
            y_zero_q  <= (op_res == '0);
            y_ones_q  <= (op_res == '1);
            y_valid_q <= 1'b1;
         end else if (out_fire) begin
            y_valid_q <= 1'b0;
         end

         if (acc_clr && out_fire)
            acc <= y_q;
         else if (acc_clr)
            acc <= '0;
         else if (out_fire)
            acc <= acc | y_q;

         if (out_fire)
            txn_count <= txn_count + CNT_W'(1);
      end
   end

   assign bus.y       = y_q;
   assign bus.y_valid = y_valid_q;
   assign bus.y_zero  = y_zero_q;
   assign bus.y_ones  = y_ones_q;
endmodule
